idex_hazard_ctrl: RTL
=====================

// Module: idex_hazard_ctrl
// PURPOSE
//  Stall/flush sequencer for the IF/ID and ID/EX pipeline registers.
//  - Detects load-use hazards and EX-stage redirects (taken branch, j/jal, jr).
//  - Freezes the front end for the duration of multi-cycle mult/div ops.
//  - Drives PC_Write, IFID_Write/IFID_Flush and IDEX_Write/IDEX_Flush; sits beside the ID-stage decoder.
// PARAMETERS
//  MD_TIMEOUT  64  max cycles in MD_WAIT before forced exit
//  CNT_W       7   width of md cycle counter (must hold MD_TIMEOUT-1)
//  PERF_W      16  width of performance counters (macro feature only)
// PORTS
//  clk          in   1      clock
//  rst          in   1      asynchronous reset, active-high
//  ID_rs        in   5      rs of instruction in ID
//  ID_rt        in   5      rt of instruction in ID
//  ID_uses_rt   in   1      ID instruction reads rt as a source
//  ID_md_start  in   1      ID instruction is a multi-cycle mult/div
//  EX_MemRead   in   1      EX instruction is a load
//  EX_rt        in   5      destination of the EX load
//  EX_redirect  in   1      EX resolved taken branch / jump / jal / jr
//  md_done      in   1      mult/div unit result ready (1-cycle pulse)
//  PC_Write     out  1      PC update enable
//  IFID_Write   out  1      IF/ID capture enable
//  IFID_Flush   out  1      IF/ID squash
//  IDEX_Write   out  1      ID/EX capture enable
//  IDEX_Flush   out  1      ID/EX control squash (bubble)
//  md_busy      out  1      FSM in MD_WAIT
//  md_err       out  1      sticky: MD_TIMEOUT expired
// BEHAVIOUR
//  - Reset (async): state=RUN, md_cnt=0, md_err=0, perf counters=0.
//    While rst high: PC_Write=IFID_Write=IDEX_Write=0, IFID_Flush=IDEX_Flush=1.
//  - Outputs are combinational from state and current inputs; state, md_cnt and md_err are registered.
//  - lu (load-use) = EX_MemRead & (EX_rt!=0) & (EX_rt==ID_rs | (ID_uses_rt & EX_rt==ID_rt)).
//  - RUN, priority redirect > lu > md > normal:
//    - EX_redirect: PC_Write=1, IFID_Flush=1, IDEX_Write=1, IDEX_Flush=1.
//      Any lu and ID_md_start are ignored; stay in RUN.
//    - lu: PC_Write=0, IFID_Write=0, IDEX_Write=1, IDEX_Flush=1.
//      Exactly one bubble per load; stay in RUN.
//    - ID_md_start: all writes=1, flushes=0 (op enters EX); next state=MD_WAIT, md_cnt<=0.
//    - else: all writes=1, flushes=0.
//  - MD_WAIT:
//    - Signals: PC_Write=0, IFID_Write=0, IDEX_Write=1, IDEX_Flush=1, IFID_Flush=0; EX_redirect ignored.
//    - md_done: return to RUN. Front end resumes the next cycle; the cycle with md_done still stalls.
//    - else if md_cnt==MD_TIMEOUT-1: md_err<=1, return to RUN.
//    - else md_cnt<=md_cnt+1 (no wrap is reachable).
//    - md_done and timeout in the same cycle: done wins, md_err unchanged.
//  - md_done in RUN is ignored. md_err clears only on rst.
//  - rst mid-MD_WAIT: immediate return to RUN, md_cnt=0, outputs per reset rule.
//  - md_busy = (state==MD_WAIT).
// CONFIGURATION
//  - IDEX_HAZ_PERF_EN defined:
//    - Adds outputs perf_stall[PERF_W-1:0] (cycles with PC_Write=0 outside rst) and perf_flush[PERF_W-1:0] (cycles with IFID_Flush=1 outside rst).
//    - Both counters saturate at all-ones and reset to 0.
//  - Not defined: those ports and counters are absent; all other behaviour is identical.
// TESTING
//  - Load-use: EX_MemRead=1, EX_rt=8, ID_rs=8 for 1 cycle.
//    -> PC_Write=0, IFID_Write=0, IDEX_Flush=1 that cycle only. Repeat with EX_rt=0 -> no stall.
//  - rt case: EX_rt=9, ID_rt=9, ID_uses_rt=0 -> no stall; ID_uses_rt=1 -> one-cycle stall.
//  - Redirect with lu: EX_redirect=1 and lu true together.
//    -> IFID_Flush=1, IDEX_Flush=1, PC_Write=1; no stall.
//  - Mult/div: ID_md_start=1 at cycle 0; md_done pulsed at cycle 5.
//    -> md_busy=1 in cycles 1..5, PC_Write=0 in cycles 1..5, PC_Write=1 at cycle 6; md_err=0.
//  - Timeout: MD_TIMEOUT=4, md_start with no md_done.
//    -> md_busy for exactly 4 cycles, then md_err=1 and held; in a second run md_done coincides with the last count -> md_err stays 0.
//  - Reset mid-op: assert rst in the 2nd MD_WAIT cycle.
//    -> md_busy=0 immediately, flushes=1, writes=0; after release, normal RUN.
//    With IDEX_HAZ_PERF_EN, perf_stall=0 after reset.

Source files
------------

// File: rtl/idex_hazard_ctrl.sv
// Stall/flush sequencer for the IF/ID and ID/EX pipeline registers.
// Optional perf counters under `define IDEX_HAZ_PERF_EN.
module idex_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7,
  parameter int PERF_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_uses_rt,
  input  logic       ID_md_start,
  input  logic       EX_MemRead,
  input  logic [4:0] EX_rt,
  input  logic       EX_redirect,
  input  logic       md_done,
  output logic       PC_Write,
  output logic       IFID_Write,
  output logic       IFID_Flush,
  output logic       IDEX_Write,
  output logic       IDEX_Flush,
  output logic       md_busy,
  output logic       md_err
`ifdef IDEX_HAZ_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_flush
`endif
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] md_cnt;
  logic             lu;
  logic             md_last;

  assign lu = EX_MemRead && (EX_rt != 5'd0) &&
              ((EX_rt == ID_rs) ||
               (ID_uses_rt && (EX_rt == ID_rt)));

  assign md_last = (md_cnt == CNT_W'(MD_TIMEOUT - 1));
  assign md_busy = (state == MD_WAIT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next state: redirect and load-use both suppress md entry
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (!EX_redirect && !lu && ID_md_start)
          state_nxt = MD_WAIT;
      end
      MD_WAIT: begin
        if (md_done || md_last)
          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // Wait-cycle counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_cnt <= '0;
      md_err <= 1'b0;
    end else if (state == RUN) begin
      md_cnt <= '0;
    end else if (!md_done) begin
      if (md_last) md_err <= 1'b1;
      else         md_cnt <= md_cnt + CNT_W'(1);
    end
  end

  // Pipeline enables: reset > md wait > redirect > load-use > run
  always_comb begin
    PC_Write   = 1'b1;
    IFID_Write = 1'b1;
    IFID_Flush = 1'b0;
    IDEX_Write = 1'b1;
    IDEX_Flush = 1'b0;
    priority case (1'b1)
      rst: begin
        PC_Write   = 1'b0;
        IFID_Write = 1'b0;
        IFID_Flush = 1'b1;
        IDEX_Write = 1'b0;
        IDEX_Flush = 1'b1;
      end
      (state == MD_WAIT): begin
        PC_Write   = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
      end
      EX_redirect: begin
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end
      lu: begin
        PC_Write   = 1'b0;
        IFID_Write = 1'b0;
        IDEX_Flush = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef IDEX_HAZ_PERF_EN
  // Saturating stall / flush cycle counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (!PC_Write && (perf_stall != '1))
        perf_stall <= perf_stall + PERF_W'(1);
      if (IFID_Flush && (perf_flush != '1))
        perf_flush <= perf_flush + PERF_W'(1);
    end
  end
`endif

endmodule
